// File: rtl/led_pkg.sv
// Shared types and helpers for the LED drain countdown bar.
package led_pkg;

  localparam int NUM_LEDS = 16;
  localparam int LEVEL_W  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Thermometer mask: bit i lit iff i < lvl.
  function automatic logic [NUM_LEDS-1:0] thermo(input logic [LEVEL_W-1:0] lvl);
    logic [NUM_LEDS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      m[i] = (LEVEL_W'(i) < lvl);
    end
    return m;
  endfunction

endpackage

// File: rtl/led_drain_timer_step_tick_gen.sv
// Step counter: tick marks the last enabled cycle of each STEP_CYCLES-long step.
module step_tick_gen #(
  parameter int STEP_CYCLES = 80000000,
  parameter int CNT_W       = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_drain_timer.sv
// Countdown bar: lights all LEDs on a start edge, then drains one LED per step.
module led_drain_timer
  import led_pkg::*;
#(
  parameter int STEP_CYCLES = 80000000,
  parameter int CNT_W       = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy,
  output logic                done,
  output logic                empty
);

  // state  | meaning
  // IDLE   | bar dark, waiting for the first start edge
  // RUN    | counting down, one LED removed per step
  // PAUSED | countdown frozen, bar held
  // DONE   | bar empty, waiting for a start edge

  state_t              state, state_nxt;
  logic [LEVEL_W-1:0]  level, level_nxt;
  logic [NUM_LEDS-1:0] led_nxt;
  logic                busy_nxt, done_nxt, empty_nxt;
  logic                start_q, start_edge;
  logic                tick, cnt_en, step;

  assign start_edge = start & ~start_q;
  // The resume cycle out of PAUSED counts, so a step loses exactly the PAUSED cycles.
  assign cnt_en     = ((state == RUN) || (state == PAUSED)) && !pause;

  step_tick_gen #(
    .STEP_CYCLES(STEP_CYCLES),
    .CNT_W      (CNT_W)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_edge),
    .en   (cnt_en),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    led_nxt   = led;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    empty_nxt = empty;
    step      = 1'b0;

    if (start_edge) begin
      state_nxt = RUN;
      level_nxt = LEVEL_W'(NUM_LEDS);
      led_nxt   = thermo(LEVEL_W'(NUM_LEDS));
      busy_nxt  = 1'b1;
      empty_nxt = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (pause) begin
            state_nxt = PAUSED;
          end else begin
            step = tick;
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_nxt = RUN;
            step      = tick;
          end
        end
        default: ;
      endcase

      if (step) begin
        if (level == LEVEL_W'(1)) begin
          state_nxt = DONE;
          level_nxt = '0;
          led_nxt   = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          empty_nxt = 1'b1;
        end else begin
          level_nxt = level - LEVEL_W'(1);
          led_nxt   = thermo(level - LEVEL_W'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      level   <= '0;
      led     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      empty   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      level   <= level_nxt;
      led     <= led_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      empty   <= empty_nxt;
      start_q <= start;
    end
  end

endmodule

// File: tb/tb_led_drain_timer.sv
// Bench for led_drain_timer with STEP_CYCLES=4: vector table, timed scenarios, random run.
module tb_led_drain_timer;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] led;
  logic        busy, done, empty;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference: countdown expressed as enabled cycles since the last start.
  bit          m_active, m_start_q;
  int          m_counted;
  logic [15:0] m_led;
  logic        m_busy, m_done, m_empty;

  typedef struct {
    logic        s;
    logic        p;
    logic [15:0] led;
    logic        busy;
    logic        done;
    logic        empty;
  } vec_t;

  vec_t tbl[17];

  led_drain_timer #(.STEP_CYCLES(STEP), .CNT_W(27)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .pause(pause),
    .led  (led),
    .busy (busy),
    .done (done),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active  = 0;
    m_start_q = 0;
    m_counted = 0;
    m_led     = 16'h0000;
    m_busy    = 0;
    m_done    = 0;
    m_empty   = 0;
  endtask

  task automatic model_step(input logic s, input logic p);
    int lvl;
    bit edge_s;
    edge_s    = s && !m_start_q;
    m_start_q = s;
    m_done    = 0;
    if (edge_s) begin
      m_active  = 1;
      m_counted = 0;
      m_led     = 16'hFFFF;
      m_busy    = 1;
      m_empty   = 0;
    end else if (m_active) begin
      if (!p) m_counted++;
      lvl = 16 - m_counted / STEP;
      if (lvl <= 0) begin
        m_active = 0;
        m_busy   = 0;
        m_done   = 1;
        m_empty  = 1;
        m_led    = 16'h0000;
      end else begin
        m_led = 16'((32'h1 << lvl) - 1);
      end
    end
  endtask

  task automatic cmp_model();
    chk("mdl_led", 32'(led), 32'(m_led));
    chk("mdl_busy", 32'(busy), 32'(m_busy));
    chk("mdl_done", 32'(done), 32'(m_done));
    chk("mdl_empty", 32'(empty), 32'(m_empty));
  endtask

  task automatic run_cycle(input logic s, input logic p);
    start = s;
    pause = p;
    @(posedge clk);
    #1;
    model_step(s, p);
    cyc++;
    cmp_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_empty", 32'(empty), 32'h0);
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h3FFF, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    // Vector table, including pause at terminal count and start edge with pause.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_cycle(tbl[i].s, tbl[i].p);
      chk($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].empty));
    end

    // Full drain, start during cycle 10.
    do_reset();
    while (cyc < 80) begin
      run_cycle(cyc == 10, 1'b0);
      if (cyc == 9)  chk("idle_led", 32'(led), 32'h0);
      if (cyc == 11) chk("full_ffff", 32'(led), 32'hFFFF);
      if (cyc == 11) chk("full_busy", 32'(busy), 32'h1);
      if (cyc == 14) chk("full_ffff_end", 32'(led), 32'hFFFF);
      if (cyc == 15) chk("full_7fff", 32'(led), 32'h7FFF);
      if (cyc == 19) chk("full_3fff", 32'(led), 32'h3FFF);
      if (cyc == 74) chk("full_0001", 32'(led), 32'h0001);
      if (cyc == 75) chk("full_done", 32'({led, done, busy, empty}), 32'({16'h0, 3'b101}));
      if (cyc == 76) chk("full_done_off", 32'({done, empty}), 32'b01);
    end

    // Pause during cycles 20..29.
    do_reset();
    while (cyc < 90) begin
      run_cycle(cyc == 10, (cyc >= 20) && (cyc <= 29));
      if (cyc == 25) chk("pause_hold", 32'(led), 32'h3FFF);
      if (cyc == 32) chk("pause_3fff", 32'(led), 32'h3FFF);
      if (cyc == 33) chk("pause_1fff", 32'(led), 32'h1FFF);
      if (cyc == 84) chk("pause_not_empty", 32'(empty), 32'h0);
      if (cyc == 85) chk("pause_empty", 32'({done, empty}), 32'b11);
    end

    // Restart mid-countdown.
    do_reset();
    while (cyc < 110) begin
      run_cycle((cyc == 10) || (cyc == 40), 1'b0);
      if (cyc == 40)  chk("rs_before", 32'(led), 32'h01FF);
      if (cyc == 41)  chk("rs_refill", 32'(led), 32'hFFFF);
      if (cyc == 75)  chk("rs_no_early_done", 32'(done), 32'h0);
      if (cyc == 104) chk("rs_not_empty", 32'(empty), 32'h0);
      if (cyc == 105) chk("rs_done", 32'({done, empty}), 32'b11);
    end

    // Start held high: a single restart only.
    do_reset();
    while (cyc < 105) begin
      run_cycle((cyc >= 10) && (cyc <= 100), 1'b0);
      if (cyc == 75) chk("held_done", 32'(done), 32'h1);
      if (cyc == 90) chk("held_stay_empty", 32'({led, busy, empty}), 32'({16'h0, 2'b01}));
    end

    // Asynchronous reset mid-countdown.
    do_reset();
    while (cyc < 50) run_cycle(cyc == 10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_led", 32'(led), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("arst_no_done", 32'({done, empty}), 32'b00);
    end
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 1'b0);

    // Random start/pause traffic against the reference.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic s, p;
      s = ($urandom_range(0, 99) < 2) ? ~start : start;
      p = ($urandom_range(0, 9) == 0) ? ~pause : pause;
      run_cycle(s, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
